fp_add_issue: RTL and testbench

Registered operand-issue stage directly upstream of the single-precision adder datapath. Accepts two IEEE-754 binary32 operands over a valid/ready handshake and classifies them. It orders them by magnitude, computes the alignment shift and add/subtract operation, and resolves special cases (NaN, Inf, zero, exact cancellation) to a bypass result. A 2-entry skid buffer gives full throughput with a fully registered `in_ready`.

---
 rtl/fp_add_pkg.sv | 40 ++++
 rtl/fp_add_issue_classify.sv | 25 ++
 rtl/fp_add_issue.sv | 148 ++++++++++++++
 tb/tb_fp_add_issue.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_add_pkg.sv
// Shared types and constants for the binary32 adder operand-issue stage.
//   fp_class_t   : operand classification (denormals are folded into ZERO)
//   fp_issue_t   : one issued operand pair plus its bypass decision
//   skid_state_t : occupancy of the output/skid register pair
//   satShift     : clamps an 8-bit exponent difference to the 5-bit shift field
package fp_add_pkg;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } fp_class_t;

  localparam logic [31:0] FP_QNAN     = 32'h7FC00000;
  localparam logic [7:0]  FP_EXP_MAX  = 8'hFF;
  localparam logic [31:0] FP_POS_ZERO = 32'h0;

  typedef struct packed {
    logic [31:0] opLarge;
    logic [31:0] opSmall;
    logic [4:0]  shift;
    logic        sub;
    logic        special;
    logic [31:0] result;
  } fp_issue_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_t;

  // Any alignment of 31 or more shifts the small mantissa out entirely,
  // so larger differences are indistinguishable downstream.
  function automatic logic [4:0] satShift(input logic [7:0] diff);
    return (diff > 8'd31) ? 5'd31 : diff[4:0];
  endfunction

endpackage

// File: rtl/fp_add_issue_classify.sv
// Combinational binary32 operand classifier.
//   op      : raw binary32 operand
//   cls     : ZERO / NORM / INF / NAN (denormals report ZERO)
//   flushed : operand with denormals replaced by a zero of the same sign
import fp_add_pkg::*;

module fp_classify (
  input  logic [31:0] op,
  output fp_class_t   cls,
  output logic [31:0] flushed
);

  always_comb begin
    cls     = NORM;
    flushed = op;
    if (op[30:23] == 8'h00) begin
      // Zero and denormal alike; the denormal's fraction is dropped here.
      cls     = ZERO;
      flushed = {op[31], 31'h0};
    end else if (op[30:23] == FP_EXP_MAX) begin
      cls = (op[22:0] == 23'h0) ? INF : NAN;
    end
  end

endmodule

// File: rtl/fp_add_issue.sv
// Registered operand-issue stage in front of the binary32 adder datapath.
// Orders the operands by magnitude, computes alignment shift and effective
// operation, and resolves NaN/Inf/zero/exact-cancellation to a bypass result.
//
// Ports:
//   clk, rst_n           : clock (rising edge), async active-low reset
//   in_valid/in_ready    : operand pair handshake (in_ready is registered)
//   in_a, in_b           : binary32 operands
//   out_valid/out_ready  : issued pair handshake
//   out_large/out_small  : operands ordered by magnitude, denormals flushed
//   out_shift            : exponent difference saturated at 31
//   out_sub              : sign_a ^ sign_b
//   out_special/out_result : bypass flag and final result (0 when not special)
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. Once out_valid is high it holds, with stable data, until out_ready.
// in_valid seen while in_ready is low is ignored.
//
// Buffering: an output register plus one skid register. in_ready is computed
// from the next state, so it falls the cycle after the skid entry fills and
// no output depends combinationally on any input.
import fp_add_pkg::*;

module fp_add_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_large,
  output logic [31:0] out_small,
  output logic [4:0]  out_shift,
  output logic        out_sub,
  output logic        out_special,
  output logic [31:0] out_result
);

  fp_class_t   clsA, clsB;
  logic [31:0] flushA, flushB;
  logic        aIsLarge;
  logic [7:0]  expDiff;
  fp_issue_t   issueNext;

  fp_classify uClassA (.op(in_a), .cls(clsA), .flushed(flushA));
  fp_classify uClassB (.op(in_b), .cls(clsB), .flushed(flushB));

  // Ordering, shift and special-case resolution for the pair on the inputs.
  always_comb begin
    issueNext = '0;
    // Ties keep in_a as the large operand.
    aIsLarge  = (flushA[30:0] >= flushB[30:0]);
    issueNext.opLarge = aIsLarge ? flushA : flushB;
    issueNext.opSmall = aIsLarge ? flushB : flushA;
    expDiff           = issueNext.opLarge[30:23] - issueNext.opSmall[30:23];
    issueNext.shift   = satShift(expDiff);
    issueNext.sub     = in_a[31] ^ in_b[31];
    issueNext.special = 1'b1;
    issueNext.result  = FP_POS_ZERO;
    if (clsA == NAN || clsB == NAN) begin
      issueNext.result = FP_QNAN;
    end else if (clsA == INF && clsB == INF && issueNext.sub) begin
      issueNext.result = FP_QNAN;
    end else if (clsA == INF) begin
      issueNext.result = flushA;
    end else if (clsB == INF) begin
      issueNext.result = flushB;
    end else if (clsA == ZERO && clsB == ZERO) begin
      // Only -0 + -0 keeps the negative sign.
      issueNext.result = {in_a[31] & in_b[31], 31'h0};
    end else if (clsA == ZERO) begin
      issueNext.result = in_b;
    end else if (clsB == ZERO) begin
      issueNext.result = in_a;
    end else if (flushA[30:0] == flushB[30:0] && issueNext.sub) begin
      issueNext.result = FP_POS_ZERO;
    end else begin
      issueNext.special = 1'b0;
    end
  end

  skid_state_t state, stateNext;
  fp_issue_t   outReg, skidReg;
  logic        accept;
  logic        loadOutNew, loadOutSkid, loadSkid;

  assign accept = in_valid & in_ready;

  always_comb begin
    stateNext   = state;
    loadOutNew  = 1'b0;
    loadOutSkid = 1'b0;
    loadSkid    = 1'b0;
    case (state)
      SKID_EMPTY: begin
        if (accept) begin
          loadOutNew = 1'b1;
          stateNext  = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (accept && out_ready) begin
          // Drain and refill in the same cycle: no bubble.
          loadOutNew = 1'b1;
        end else if (accept) begin
          loadSkid  = 1'b1;
          stateNext = SKID_TWO;
        end else if (out_ready) begin
          stateNext = SKID_EMPTY;
        end
      end
      SKID_TWO: begin
        if (out_ready) begin
          loadOutSkid = 1'b1;
          stateNext   = SKID_ONE;
        end
      end
      default: stateNext = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SKID_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      outReg    <= '0;
      skidReg   <= '0;
    end else begin
      state     <= stateNext;
      in_ready  <= (stateNext != SKID_TWO);
      out_valid <= (stateNext != SKID_EMPTY);
      if (loadOutNew) outReg <= issueNext;
      if (loadOutSkid) outReg <= skidReg;
      if (loadSkid) skidReg <= issueNext;
    end
  end

  assign out_large   = outReg.opLarge;
  assign out_small   = outReg.opSmall;
  assign out_shift   = outReg.shift;
  assign out_sub     = outReg.sub;
  assign out_special = outReg.special;
  assign out_result  = outReg.result;

endmodule

// File: tb/tb_fp_add_issue.sv
// Self-checking bench for fp_add_issue: directed operand pairs with
// hand-derived expectations, a stalled random stream, and a mid-flight reset.
module tb_fp_add_issue;

  localparam int W = 103;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_large, out_small, out_result;
  logic [4:0]  out_shift;
  logic        out_sub, out_special;

  always #5 clk = ~clk;

  fp_add_issue dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_large(out_large), .out_small(out_small), .out_shift(out_shift),
    .out_sub(out_sub), .out_special(out_special), .out_result(out_result)
  );

  logic [W-1:0] obs_vec;
  assign obs_vec = {out_large, out_small, out_shift, out_sub, out_special, out_result};

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [31:0] l, input logic [31:0] s,
                                      input logic [4:0] sh, input logic sb, input logic sp,
                                      input logic [31:0] r);
    return {l, s, sh, sb, sp, r};
  endfunction

  // Reference for normal (non-special-class) operands only.
  function automatic logic [W-1:0] model_norm(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] l, s;
    int d;
    logic sp;
    if (a[30:0] >= b[30:0]) begin l = a; s = b; end
    else begin l = b; s = a; end
    d = int'(l[30:23]) - int'(s[30:23]);
    if (d > 31) d = 31;
    sp = (a[30:0] == b[30:0]) && (a[31] != b[31]);
    return mk(l, s, 5'(d), a[31] ^ b[31], sp, 32'h0);
  endfunction

  // Monitor: occupancy, hold-while-stalled, and in-order output checks.
  logic         stall_prev = 1'b0;
  logic [W-1:0] held_vec;
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", W'(in_ready), W'(exp_q.size() < 2));
      check("out_valid", W'(out_valid), W'(exp_q.size() > 0));
      if (stall_prev) check("stable", obs_vec, held_vec);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $error("FAIL unexpected_output observed=%h expected=none", obs_vec);
        end else begin
          check("issue", obs_vec, exp_q.pop_front());
        end
      end
      stall_prev = out_valid && !out_ready;
      held_vec   = obs_vec;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // ---------------- drivers ----------------
  logic toggle_on = 1'b0;
  int   pat_idx   = 0;
  logic pat [6]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (toggle_on) begin
        out_ready = pat[pat_idx % 6];
        pat_idx++;
      end
    end
  end

  // Called one time unit after a rising edge; returns at the same phase.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [W-1:0] e);
    int   n = 0;
    logic acc = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    while (!acc && n < 50) begin
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (acc) exp_q.push_back(e);
    else begin
      compared++;
      mismatched++;
      $error("FAIL accept_timeout observed=no_accept expected=accept a=%h b=%h", a, b);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $error("FAIL drain_timeout observed=%0d expected=0", exp_q.size());
    end
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] sa [8];
  logic [31:0] sb [8];

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = 32'h0;
    in_b      = 32'h0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", W'(in_ready), W'(1'b1));
    check("reset_out_valid", W'(out_valid), W'(1'b0));
    check("reset_data", obs_vec, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(32'h3FC00000, 32'h40000000, mk(32'h40000000, 32'h3FC00000, 5'd1, 1'b0, 1'b0, 32'h0));
    drain();
    send(32'h7F800000, 32'hFF800000, mk(32'h7F800000, 32'hFF800000, 5'd0, 1'b1, 1'b1, 32'h7FC00000));
    send(32'h7F800001, 32'h3F800000, mk(32'h7F800001, 32'h3F800000, 5'd31, 1'b0, 1'b1, 32'h7FC00000));
    send(32'h00000001, 32'hBF800000, mk(32'hBF800000, 32'h00000000, 5'd31, 1'b1, 1'b1, 32'hBF800000));
    send(32'h80000000, 32'h80000000, mk(32'h80000000, 32'h80000000, 5'd0, 1'b0, 1'b1, 32'h80000000));
    send(32'h41200000, 32'hC1200000, mk(32'h41200000, 32'hC1200000, 5'd0, 1'b1, 1'b1, 32'h00000000));
    send(32'h4B000000, 32'h33800000, mk(32'h4B000000, 32'h33800000, 5'd31, 1'b0, 1'b0, 32'h0));
    send(32'h7F800000, 32'h3F800000, mk(32'h7F800000, 32'h3F800000, 5'd31, 1'b0, 1'b1, 32'h7F800000));
    send(32'h3F800000, 32'h00000000, mk(32'h3F800000, 32'h00000000, 5'd31, 1'b0, 1'b1, 32'h3F800000));
    send(32'hC0000000, 32'h3F800000, mk(32'hC0000000, 32'h3F800000, 5'd1, 1'b1, 1'b0, 32'h0));
    send(32'h3F800000, 32'hC0400000, mk(32'hC0400000, 32'h3F800000, 5'd1, 1'b1, 1'b0, 32'h0));
    drain();

    // Stream with in_valid held and out_ready toggling 1,0,0,1,1,0,...
    for (int i = 0; i < 8; i++) begin
      sa[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 140)), 23'($urandom)};
      sb[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 140)), 23'($urandom)};
    end
    toggle_on = 1'b1;
    for (int i = 0; i < 8; i++) send(sa[i], sb[i], model_norm(sa[i], sb[i]));
    drain();
    toggle_on = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Fill both entries, then reset mid-cycle.
    out_ready = 1'b0;
    send(32'h3F800000, 32'h40400000, mk(32'h40400000, 32'h3F800000, 5'd1, 1'b0, 1'b0, 32'h0));
    send(32'h40000000, 32'h3F000000, mk(32'h40000000, 32'h3F000000, 5'd2, 1'b0, 1'b0, 32'h0));
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midreset_out_valid", W'(out_valid), W'(1'b0));
    check("midreset_in_ready", W'(in_ready), W'(1'b1));
    check("midreset_data", obs_vec, '0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("post_reset_in_ready", W'(in_ready), W'(1'b1));
    check("post_reset_out_valid", W'(out_valid), W'(1'b0));
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    send(32'h40A00000, 32'h3F000000, mk(32'h40A00000, 32'h3F000000, 5'd3, 1'b0, 1'b0, 32'h0));
    drain();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("leftover", W'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
